// File: rtl/fp_mac_arb_pkg.sv
// Shared types for the fp_mac arbiter: MAC operand/result structs, FSM states
// and the result width.
package fp_mac_arb_pkg;

    localparam int FP_MAC_RES_W = 110;

    // d = {a, 54'b0} +/- b*c, so a is 56 bits and b/c are 55-bit signed
    typedef struct packed {
        logic [55:0] a;
        logic [54:0] b;
        logic [54:0] c;
        logic        op;
        logic        valid;
    } fp_mac_in_type;

    typedef struct packed {
        logic [FP_MAC_RES_W-1:0] d;
        logic                    ready;
    } fp_mac_out_type;

    typedef enum logic {IDLE, WAIT} fp_mac_arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_mac_arb_if.sv
// Requester/MAC bus of fp_mac_arb; slave is the arbiter side.
interface fp_mac_arb_if #(parameter int N_REQ = 2);
    import fp_mac_arb_pkg::*;

    logic [N_REQ-1:0]               req_valid_i;
    fp_mac_in_type [N_REQ-1:0]      req_i;
    logic [N_REQ-1:0]               req_ready_o;
    logic                           flush_i;
    logic [N_REQ-1:0]               resp_valid_o;
    logic [FP_MAC_RES_W-1:0]        resp_d_o;
    fp_mac_in_type                  mac_o;
    fp_mac_out_type                 mac_i;
    logic                           busy_o;

    modport master (
        output req_valid_i, req_i, flush_i, mac_i,
        input  req_ready_o, resp_valid_o, resp_d_o, mac_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_i, flush_i, mac_i,
        output req_ready_o, resp_valid_o, resp_d_o, mac_o, busy_o
    );

endinterface

// File: rtl/fp_mac_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import fp_mac_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mac_arb.sv
// Shares one fp_mac between N_REQ requesters: round-robin issue while idle,
// then waits for the MAC ready pulse and routes the result to the owner.
module fp_mac_arb
    import fp_mac_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic         clk,
    input  logic         rst,
    fp_mac_arb_if.slave  bus
);

    localparam int PW = idx_w(N_REQ);

    fp_mac_arb_state_t state;
    logic [PW-1:0]     rr_ptr, owner, gnt_idx, next_ptr;
    logic              kill, issue;
    logic [N_REQ-1:0]  gnt, owner_oh;
    fp_mac_in_type     win, held;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (bus.req_valid_i),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign issue = (state == IDLE) && (|bus.req_valid_i) && !bus.flush_i;

    always_comb begin
        gnt_idx = '0;
        win     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
                win     = bus.req_i[i];
            end
        end
        win.valid = 1'b0;
    end

    assign next_ptr = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign owner_oh = N_REQ'(1) << owner;

    assign bus.req_ready_o = issue ? gnt : '0;
    assign bus.busy_o      = (state == WAIT);

    // Operand fields stay at the last issued set so the MAC input is quiet
    always_comb begin
        bus.mac_o = held;
        if (issue) begin
            bus.mac_o       = win;
            bus.mac_o.valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            owner            <= '0;
            kill             <= 1'b0;
            held             <= '0;
            bus.resp_valid_o <= '0;
            bus.resp_d_o     <= '0;
        end else begin
            bus.resp_valid_o <= '0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        owner  <= gnt_idx;
                        kill   <= 1'b0;
                        rr_ptr <= next_ptr;
                        held   <= win;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush_i)
                        kill <= 1'b1;
                    // A flush coinciding with ready still suppresses the response
                    if (bus.mac_i.ready) begin
                        bus.resp_d_o <= bus.mac_i.d;
                        if (!kill && !bus.flush_i)
                            bus.resp_valid_o <= owner_oh;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mac_arb.sv
// Scoreboard bench for fp_mac_arb with a variable-latency behavioural MAC.
module tb_fp_mac_arb;
    import fp_mac_arb_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mac_arb_if #(.N_REQ(N)) bus ();
    fp_mac_arb #(.N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0]   vld;
        logic [109:0]   d;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_ready = -100;
    int   lat = 3;
    logic chk_gap = 1'b0;

    // Behavioural MAC: latches on valid, ready pulses in cycle T0+lat
    logic         m_busy, m_ready;
    int           m_cnt;
    logic [109:0] m_d, m_res;

    function automatic logic [109:0] mac_fn(input fp_mac_in_type m);
        logic signed [109:0] bx, cx;
        bx = {{55{m.b[54]}}, m.b};
        cx = {{55{m.c[54]}}, m.c};
        return m.op ? ({m.a, 54'b0} - (bx * cx)) : ({m.a, 54'b0} + (bx * cx));
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_cnt   <= 0;
            m_d     <= '0;
            m_res   <= '0;
        end else begin
            m_ready <= 1'b0;
            if (m_busy) begin
                if (m_cnt == lat - 1) begin
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                    m_d     <= m_res;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (bus.mac_o.valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_res  <= mac_fn(bus.mac_o);
            end
        end
    end

    assign bus.mac_i = '{d: m_d, ready: m_ready};

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endfunction

    // Monitor: scoreboard pops, grant log, issue and latency invariants
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mac_i.ready) last_ready = cyc;
            if (bus.mac_o.valid) begin
                chk("issue_while_busy", bus.busy_o, 0);
                chk("ready_onehot", $countones(bus.req_ready_o), 1);
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready_o[i]) begin
                    grants.push_back(i);
                    if (chk_gap) chk("accept_gap", cyc - last_ready, 1);
                end
            end
            if (bus.resp_valid_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", bus.resp_valid_o, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner", bus.resp_valid_o, e.vld);
                    chk("resp_d", bus.resp_d_o, e.d);
                    chk("resp_latency", cyc - last_ready, 1);
                end
            end
        end
    end

    task automatic expect_resp(input int r, input logic [109:0] d);
        exp_t e;
        e.vld = N'(1) << r;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic set_req(input int r, input logic [55:0] a, input logic [54:0] b,
                           input logic [54:0] c, input logic op);
        bus.req_i[r]       = '{a: a, b: b, c: c, op: op, valid: 1'b0};
        bus.req_valid_i[r] = 1'b1;
    endtask

    task automatic send(input int r, input logic [55:0] a, input logic [54:0] b,
                        input logic [54:0] c, input logic op);
        logic got;
        set_req(r, a, b, c, op);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            got = bus.req_ready_o[r];
            @(posedge clk);
            #1;
            if (got) begin
                bus.req_valid_i[r] = 1'b0;
                return;
            end
        end
        bus.req_valid_i[r] = 1'b0;
        timeout("send_accept");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (!bus.busy_o && sb.size() == 0) begin
                repeat (2) @(posedge clk);
                #1;
                return;
            end
        end
        timeout("drain");
    endtask

    task automatic wait_grants(input int n, input string nm);
        for (int k = 0; k < 100; k++) begin
            if (grants.size() >= n) return;
            @(posedge clk);
            #1;
        end
        timeout(nm);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_busy"}, bus.busy_o, 0);
        chk({nm, "_resp_valid"}, bus.resp_valid_o, 0);
        chk({nm, "_resp_d"}, bus.resp_d_o, 0);
        chk({nm, "_mac_o"}, bus.mac_o, 0);
        chk({nm, "_req_ready"}, bus.req_ready_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        rst             = 1'b1;
        bus.req_valid_i = '0;
        bus.req_i       = '0;
        bus.flush_i     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requests on each port
        expect_resp(0, 110'd6);
        send(0, 56'd0, 55'd2, 55'd3, 1'b0);
        wait_drain();
        expect_resp(1, 110'h3F_FFFF_FFFF_FFFA);
        send(1, 56'd1, 55'd2, 55'd3, 1'b1);
        wait_drain();

        // Both held valid for four ops: alternate grants, issue at ready+1
        lat = 4;
        g0  = grants.size();
        expect_resp(0, 110'd35);
        expect_resp(1, 110'h3F_FFFF_FFFF_FFF0);
        expect_resp(0, 110'd35);
        expect_resp(1, 110'h3F_FFFF_FFFF_FFF0);
        set_req(0, 56'd0, 55'd5, 55'd7, 1'b0);
        set_req(1, 56'd1, 55'd4, 55'd4, 1'b1);
        wait_grants(g0 + 1, "b2b_first");
        chk_gap = 1'b1;
        wait_grants(g0 + 4, "b2b_all");
        bus.req_valid_i = '0;
        chk_gap = 1'b0;
        wait_drain();
        if (grants.size() >= g0 + 4) begin
            chk("b2b_order0", grants[g0],     0);
            chk("b2b_order1", grants[g0 + 1], 1);
            chk("b2b_order2", grants[g0 + 2], 0);
            chk("b2b_order3", grants[g0 + 3], 1);
        end else begin
            timeout("b2b_order");
        end

        // Flush mid-WAIT: result dropped, waiting requester issues at ready+1
        lat = 5;
        send(0, 56'd0, 55'd3, 55'd3, 1'b0);
        @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        expect_resp(1, 110'd56);
        chk_gap = 1'b1;
        send(1, 56'd0, 55'd7, 55'd8, 1'b0);
        chk_gap = 1'b0;
        wait_drain();

        // Flush in the same cycle as ready
        lat = 3;
        send(0, 56'd0, 55'd6, 55'd7, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.mac_i.ready) break;
        end
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        expect_resp(1, 110'h40_0000_0000_0006);
        send(1, 56'd1, 55'd2, 55'd3, 1'b0);
        wait_drain();

        // Flush in IDLE blocks issue for that cycle only
        set_req(0, 56'd2, 55'd1, 55'd1, 1'b0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_idle_block", bus.req_ready_o, 2'b00);
        chk("flush_idle_valid", bus.mac_o.valid, 0);
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        expect_resp(0, 110'h80_0000_0000_0001);
        @(negedge clk);
        chk("flush_idle_accept", bus.req_ready_o, 2'b01);
        @(posedge clk);
        #1 bus.req_valid_i[0] = 1'b0;
        wait_drain();

        // Reset during WAIT, then both requesters: rr_ptr restarts at 0
        lat = 5;
        send(0, 56'd0, 55'd9, 55'd9, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        g0 = grants.size();
        expect_resp(0, 110'd1);
        expect_resp(1, 110'h3F_FFFF_FFFF_FFFD);
        set_req(0, 56'd0, 55'd1, 55'd1, 1'b0);
        set_req(1, 56'd1, 55'h7F_FFFF_FFFF_FFFF, 55'd3, 1'b0);
        wait_grants(g0 + 1, "post_reset_first");
        bus.req_valid_i[0] = 1'b0;
        wait_grants(g0 + 2, "post_reset_second");
        bus.req_valid_i[1] = 1'b0;
        wait_drain();
        if (grants.size() >= g0 + 2) begin
            chk("post_reset_order0", grants[g0],     0);
            chk("post_reset_order1", grants[g0 + 1], 1);
        end else begin
            timeout("post_reset_order");
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mac_arb.md
# fp_mac_arb

Round-robin arbiter and sequencer that shares one `fp_mac` multiply-accumulate unit between `N_REQ` requesters inside the FPU, e.g. the divide and square-root iteration engines. It accepts one operand set at a time and drives the MAC's single-cycle `valid` only while the MAC is idle. It tracks the outstanding operation until the MAC's `ready` pulse, then returns the 110-bit result to the owning requester. Flushed operations are drained and their results discarded.

## Interface
- `N_REQ`, default 2, number of requesters (≥1).
- `clk` in 1, clock; all logic is on the rising edge.
- `rst` in 1, reset, synchronous and active-high.
- `req_valid_i` in `N_REQ`, per-requester request; held until accepted.
- `req_i` in `N_REQ` × `fp_mac_in_type`, operands `a`/`b`/`c`/`op` per requester; the `.valid` field is ignored.
- `req_ready_o` out `N_REQ`, one-hot accept; combinational from `req_valid_i`.
- `flush_i` in 1, kills the outstanding operation's response and blocks issue this cycle.
- `resp_valid_o` out `N_REQ`, one-hot response pulse, registered.
- `resp_d_o` out 110, result; valid while `resp_valid_o` is nonzero.
- `mac_o` out `fp_mac_in_type`, to the MAC.
- `mac_i` in `fp_mac_out_type`, from the MAC (`d`, `ready`).
- `busy_o` out 1, high while an operation is outstanding.

## Operation
- States: IDLE and WAIT.
- IDLE, issue condition: any `req_valid_i` set and `flush_i`=0.
  - Winner `g` is the first set bit at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - `req_ready_o[g]`=1.
  - `mac_o` = `{req_i[g].a, .b, .c, .op, valid=1}`.
  - Registered: `owner`←g, `kill`←0, `rr_ptr`←(g+1) mod `N_REQ`, state→WAIT.
- IDLE with no issue: `mac_o.valid`=0 and `mac_o` operand fields hold their last values. `rr_ptr` is unchanged.
- WAIT: `mac_o.valid`=0 and `req_ready_o`=0. `flush_i`=1 sets `kill`.
- WAIT with `mac_i.ready`=1:
  - Registered: `resp_d_o`←`mac_i.d`.
  - `resp_valid_o`←onehot(`owner`), unless `kill` or `flush_i` is set, in which case it gets 0.
  - state→IDLE.
- `busy_o` = (state==WAIT).
- `mac_i.ready` seen in IDLE is spurious and is ignored.
- `resp_valid_o` is a one-cycle pulse. `resp_d_o` holds its value until the next capture.
- `N_REQ`=1 degenerates to a pass-through sequencer with `rr_ptr` fixed at 0.
- Arithmetic is entirely inside the MAC: d = {a,54'b0} ± b·c (signed, 110-bit wrap). `op`=1 subtracts; a=0 returns ±b·c.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `owner`=0, `kill`=0.
  - `resp_valid_o`=0, `resp_d_o`=0.
  - `mac_o` all fields 0, `req_ready_o`=0, `busy_o`=0.
- Accept cycle T0: `req_ready_o` and `mac_o.valid` are high in the same cycle; the MAC latches operands at the end of T0.
- MAC `ready` arrives in cycle T0+L, where L ≥ 3 depends on the variable-latency multiplier. `resp_valid_o` is then high in T0+L+1.
- In T0+L+1 the MAC has returned to idle, so a new accept is legal in that same cycle. Back-to-back issue interval is therefore L+1.
- Simultaneous `flush_i` and `mac_i.ready` in WAIT: flush wins, no response, state→IDLE.
- Flush during a drain does not abort the MAC. Issue stays blocked until `ready`.
- `rst` mid-operation: everything returns to reset values. The MAC must see the same reset (`rst_n = ~rst` at integration). Stale results are never forwarded.

## Structure
- `fp_types` gains:
  - the `fp_mac_arb_state_t` enum (IDLE, WAIT);
  - `FP_MAC_RES_W` = 110.
- `fp_mac_in_type` and `fp_mac_out_type` are reused unchanged.
- One sub-module, `rr_arbiter #(N)`: inputs `req`, `ptr`; output one-hot `gnt`; purely combinational.
- `fp_mac` itself is instantiated by the integrating level (FPU top), not inside this block.

## Test plan
- Single request, req0 with a=0, b=2, c=3, op=0 → accepted at T0, one `mac_o.valid` pulse. `resp_valid_o`=01 and `resp_d_o`=6 one cycle after `mac_i.ready`.
- req1 with a=1, b=2, c=3, op=1 → `resp_valid_o`=10, `resp_d_o`=2^54−6.
- Both requesters held valid continuously for 4 operations → grant order 0,1,0,1.
  - `mac_o.valid` never asserted while `busy_o`=1.
  - Each new accept occurs exactly one cycle after the prior `ready`.
- `flush_i` pulsed mid-WAIT, and separately in the same cycle as `ready` → no `resp_valid_o`. Next request accepted only after `ready`; its result is delivered normally.
- `flush_i`=1 in IDLE with req0 valid → `req_ready_o`=0 that cycle; accepted the next cycle when `flush_i`=0.
- `rst` asserted during WAIT, with the MAC reset too → all outputs at reset values and no response. Post-reset req1 is granted first only if req0 is idle, since `rr_ptr`=0.
